pacman_dir_ctrl: RTL and testbench
==================================

# pacman_dir_ctrl

Upstream keyboard-to-motion stage for the player sprite. It debounces the four raw arrow-key levels once per frame and buffers the most recent turn request. The request is released only when the sprite's current top-left position allows the turn on the tile grid. It drives the four direction inputs of the motion block: down, right, up, left.

## Interface
- `DEBOUNCE_FRAMES`, default 2. Number of consecutive frame samples a key must be high to count as pressed (1..7).
- `TILE_LOG2`, default 5. Tile size is 2^TILE_LOG2 pixels; the grid origin is pixel 0.
- `PENDING_TIMEOUT`, default 15. Frames a buffered request survives without being issued (1..63).
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-clock pulse per frame.
- `key_right`, `key_left`, `key_down`, `key_up` in 1 each: raw key levels, active-high, synchronous to `clk`.
- `topLeftX`, `topLeftY` in 11 signed each: current sprite position, fed back from the motion block.
- `move_down`, `move_right`, `move_up`, `move_left` out 1 each: direction commands to the motion block. At most one is high at any time.
- `pending_dir` out 3: buffered request. Encoding: 0 none, 1 right, 2 left, 3 down, 4 up.
- `cur_dir` out 3: last issued direction, same encoding.

## Operation
- States:
  - `IDLE_ST`: after reset.
  - `WAIT_ST`: waiting for a frame.
  - `SAMPLE_ST`: debounce and request capture.
  - `DECIDE_ST`: issue decision.
- Transitions:
  - `IDLE_ST`→`WAIT_ST` on the first `startOfFrame`.
  - `WAIT_ST`→`SAMPLE_ST` on `startOfFrame`. The four keys are registered in that same cycle.
  - `SAMPLE_ST`→`DECIDE_ST` unconditionally.
  - `DECIDE_ST`→`WAIT_ST` unconditionally.
- Debounce, in `SAMPLE_ST`:
  - Each key has a 3-bit saturating counter. A registered high increments it, saturating at `DEBOUNCE_FRAMES`. A registered low clears it.
  - Debounced = (counter == `DEBOUNCE_FRAMES`).
  - A rising edge of a debounced flag is a new request.
  - Several simultaneous new requests resolve by priority up > down > left > right.
  - A new request overwrites `pending_dir` and clears the timeout counter.
- Decision, in `DECIDE_ST`, with `pending_dir` ≠ 0:
  - Pending equals `cur_dir`: clear pending; issue nothing.
  - `cur_dir` = none, or pending is the reverse of `cur_dir`: issue immediately.
  - Pending is vertical and `cur_dir` is horizontal: issue only if `topLeftX[TILE_LOG2-1:0]` == 0.
  - Pending is horizontal and `cur_dir` is vertical: issue only if `topLeftY[TILE_LOG2-1:0]` == 0.
  - The alignment test uses the two's-complement low bits, so negative positions need no special handling.
  - Not issued: increment the timeout counter. When it reaches `PENDING_TIMEOUT`, clear pending.
- Issue:
  - `cur_dir` ← pending; pending ← 0; the timeout counter clears.
  - The matching `move_*` output is loaded; the other three go low.
- Hold: an issued `move_*` stays high until the clock edge after the next `startOfFrame`. This guarantees the motion block's collection state sees it for a full frame.
- A key that is held down makes no further requests after its first debounced edge.
- Reset (any time, including mid-hold):
  - State goes to `IDLE_ST`.
  - All counters, `pending_dir`, `cur_dir` and `move_*` go to 0.

## Timing
- Reset values: all outputs 0.
- Let `startOfFrame` be high in cycle T while in `WAIT_ST`:
  - Keys are sampled at T.
  - `SAMPLE_ST` is at T+1; `pending_dir` updates at the edge ending T+1.
  - `DECIDE_ST` is at T+2.
  - `move_*` and `cur_dir` are visible from T+3.
- Latency from the frame the key first reads high to `move_*` high: (`DEBOUNCE_FRAMES`−1) frames + 3 clocks, when issue is immediate.
- The hold ends on the edge after the next `startOfFrame`. If a new issue and a hold end coincide, the new issue wins.
- A `startOfFrame` arriving in `SAMPLE_ST` or `DECIDE_ST` is ignored. Frame spacing is far greater than 3 clocks.

## Test plan
- Immediate start: after reset, `key_right` high for frames 1–3 with `DEBOUNCE_FRAMES`=2.
  - Required: `move_right` rises 3 clocks after the frame-2 `startOfFrame`.
  - Required: `cur_dir` becomes 1.
  - Required: `move_right` falls one clock after the frame-3 `startOfFrame`.
- Perpendicular turn buffered: `cur_dir`=right, `topLeftX`=100, press up.
  - Required: `pending_dir`=4 and no `move_up`.
  - Then set `topLeftX`=128. Required: `move_up` issued at that frame's `DECIDE_ST`, and `pending_dir`→0.
- Reversal: `cur_dir`=right, `topLeftX`=101, press left. Required: `move_left` issued in the same frame the request becomes pending, with no alignment wait.
- Timeout: `cur_dir`=down, `topLeftY` never a multiple of 32, press left.
  - Required: `pending_dir`=2 for 15 decisions, then 0.
  - Required: no `move_*`.
- Simultaneous keys and glitch:
  - `key_up` and `key_left` rise together. Required: pending=4.
  - A 1-frame key pulse. Required: no request.
- Reset mid-hold: assert `resetN`=0 while `move_down` is high. Required: all outputs 0 immediately, then a first issue needs a fresh full debounce.

Source files
------------

// File: rtl/pacman_dir_ctrl.sv
// Keyboard-to-motion stage: debounces arrow keys once per frame, buffers the latest
// turn request and releases it when the sprite's tile alignment allows the turn.
module pacman_dir_ctrl #(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int TILE_LOG2       = 5,
  parameter int PENDING_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               key_right,
  input  logic               key_left,
  input  logic               key_down,
  input  logic               key_up,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  output logic               move_down,
  output logic               move_right,
  output logic               move_up,
  output logic               move_left,
  output logic [2:0]         pending_dir,
  output logic [2:0]         cur_dir
);

  typedef enum logic [1:0] {IDLE_ST, WAIT_ST, SAMPLE_ST, DECIDE_ST} state_t;

  localparam logic [2:0]  DIR_NONE  = 3'd0;
  localparam logic [2:0]  DIR_RIGHT = 3'd1;
  localparam logic [2:0]  DIR_LEFT  = 3'd2;
  localparam logic [2:0]  DIR_DOWN  = 3'd3;
  localparam logic [2:0]  DIR_UP    = 3'd4;
  localparam logic [2:0]  DEB_MAX   = 3'(DEBOUNCE_FRAMES);
  localparam logic [5:0]  TMO_MAX   = 6'(PENDING_TIMEOUT);
  localparam logic [10:0] TILE_MASK = 11'((1 << TILE_LOG2) - 1);

  function automatic logic is_vert(input logic [2:0] d);
    return (d == DIR_DOWN) || (d == DIR_UP);
  endfunction

  function automatic logic [2:0] reverse_of(input logic [2:0] d);
    case (d)
      DIR_RIGHT: return DIR_LEFT;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_DOWN:  return DIR_UP;
      DIR_UP:    return DIR_DOWN;
      default:   return DIR_NONE;
    endcase
  endfunction

  // Output bit order {down, right, up, left}
  function automatic logic [3:0] dir_onehot(input logic [2:0] d);
    case (d)
      DIR_DOWN:  return 4'b1000;
      DIR_RIGHT: return 4'b0100;
      DIR_UP:    return 4'b0010;
      DIR_LEFT:  return 4'b0001;
      default:   return 4'b0000;
    endcase
  endfunction

  state_t     state;
  logic [3:0] key_q;          // {up, down, left, right}: index i maps to code i+1
  logic [2:0] deb_cnt [4];
  logic [2:0] deb_cnt_nxt [4];
  logic [5:0] tmo_cnt;
  logic [3:0] move_q;
  logic [3:0] new_req;
  logic [2:0] req_dir;
  logic       x_aligned;
  logic       y_aligned;
  logic       issue_ok;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    new_req = '0;
    req_dir = DIR_NONE;
    for (int i = 0; i < 4; i++) begin
      if (!key_q[i])                 deb_cnt_nxt[i] = '0;
      else if (deb_cnt[i] == DEB_MAX) deb_cnt_nxt[i] = deb_cnt[i];
      else                           deb_cnt_nxt[i] = deb_cnt[i] + 3'd1;
      new_req[i] = (deb_cnt_nxt[i] == DEB_MAX) && (deb_cnt[i] != DEB_MAX);
    end
    // Highest code wins, which matches up > down > left > right
    for (int i = 0; i < 4; i++)
      if (new_req[i]) req_dir = 3'(i + 1);
  end

  // Two's-complement low bits: negative multiples of the tile size also read as aligned
  assign x_aligned = (topLeftX & TILE_MASK) == '0;
  assign y_aligned = (topLeftY & TILE_MASK) == '0;

  assign issue_ok = (cur_dir == DIR_NONE)
                 || (pending_dir == reverse_of(cur_dir))
                 || ( is_vert(pending_dir) && !is_vert(cur_dir) && x_aligned)
                 || (!is_vert(pending_dir) &&  is_vert(cur_dir) && y_aligned);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE_ST;
      key_q       <= '0;
      tmo_cnt     <= '0;
      move_q      <= '0;
      pending_dir <= DIR_NONE;
      cur_dir     <= DIR_NONE;
      // NOTE: these counters are a handful of flops, not a RAM, so resetting them is cheap and required.
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      case (state)
        IDLE_ST: if (startOfFrame) state <= WAIT_ST;
        WAIT_ST: begin
          if (startOfFrame) begin
            key_q  <= {key_up, key_down, key_left, key_right};
            move_q <= '0;   // hold ends on the edge after the next frame start
            state  <= SAMPLE_ST;
          end
        end
        SAMPLE_ST: begin
          for (int i = 0; i < 4; i++) deb_cnt[i] <= deb_cnt_nxt[i];
          if (req_dir != DIR_NONE) begin
            pending_dir <= req_dir;
            tmo_cnt     <= '0;
          end
          state <= DECIDE_ST;
        end
        DECIDE_ST: begin
          state <= WAIT_ST;
          if (pending_dir != DIR_NONE) begin
            if (pending_dir == cur_dir) begin
              pending_dir <= DIR_NONE;
              tmo_cnt     <= '0;
            end else if (issue_ok) begin
              cur_dir     <= pending_dir;
              move_q      <= dir_onehot(pending_dir);
              pending_dir <= DIR_NONE;
              tmo_cnt     <= '0;
            end else if (tmo_cnt + 6'd1 == TMO_MAX) begin
              pending_dir <= DIR_NONE;
              tmo_cnt     <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 6'd1;
            end
          end
        end
        default: state <= IDLE_ST;
      endcase
    end
  end

  assign {move_down, move_right, move_up, move_left} = move_q;

endmodule

// File: tb/tb_pacman_dir_ctrl.sv
// Scoreboard bench for pacman_dir_ctrl: a frame-level reference model queues the
// expected outputs per frame; a monitor compares them at fixed offsets after each frame start.
module tb_pacman_dir_ctrl;

  localparam int DEB   = 2;
  localparam int TLOG  = 5;
  localparam int TMO   = 15;
  localparam int TILE  = 1 << TLOG;
  localparam int FRAME = 8;

  localparam bit [3:0] K_R = 4'b0001;
  localparam bit [3:0] K_L = 4'b0010;
  localparam bit [3:0] K_D = 4'b0100;
  localparam bit [3:0] K_U = 4'b1000;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic key_right = 1'b0, key_left = 1'b0, key_down = 1'b0, key_up = 1'b0;
  logic signed [10:0] topLeftX = '0, topLeftY = '0;
  logic move_down, move_right, move_up, move_left;
  logic [2:0] pending_dir, cur_dir;

  pacman_dir_ctrl #(.DEBOUNCE_FRAMES(DEB), .TILE_LOG2(TLOG), .PENDING_TIMEOUT(TMO)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .key_right(key_right), .key_left(key_left), .key_down(key_down), .key_up(key_up),
    .topLeftX(topLeftX), .topLeftY(topLeftY),
    .move_down(move_down), .move_right(move_right), .move_up(move_up), .move_left(move_left),
    .pending_dir(pending_dir), .cur_dir(cur_dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit chk;
    int pend_s;  // pending right after the sample step
    int move;    // {down, right, up, left} after the decision
    int cur;
    int pend;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model state, kept per frame
  bit [7:0] hist [4];
  bit [3:0] deb_prev;
  int m_cur, m_pend, m_tmo;
  bit m_idle;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int move_bits(input int d);
    case (d)
      3: return 8;
      1: return 4;
      4: return 2;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit vert(input int d);
    return d == 3 || d == 4;
  endfunction

  function automatic int rev(input int d);
    case (d)
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) hist[i] = '0;
    deb_prev = '0;
    m_cur = 0; m_pend = 0; m_tmo = 0;
    m_idle = 1'b1;
  endtask

  function automatic exp_t model_frame(input bit [3:0] keys, input int x, input int y);
    exp_t e;
    bit [3:0] deb_now;
    bit [7:0] mask;
    int req;
    bit go;
    e.chk = 1'b1;
    e.move = 0;
    mask = 8'((1 << DEB) - 1);
    req = 0;
    // A key is debounced once its last DEB frame samples were all high
    for (int i = 0; i < 4; i++) begin
      hist[i] = {hist[i][6:0], keys[i]};
      deb_now[i] = (hist[i] & mask) == mask;
      if (deb_now[i] && !deb_prev[i]) req = i + 1;
    end
    deb_prev = deb_now;
    if (req != 0) begin
      m_pend = req;
      m_tmo = 0;
    end
    e.pend_s = m_pend;
    if (m_pend != 0) begin
      if (m_pend == m_cur) begin
        m_pend = 0;
      end else begin
        go = (m_cur == 0) || (m_pend == rev(m_cur))
          || (vert(m_pend) && !vert(m_cur) && (x % TILE == 0))
          || (!vert(m_pend) && vert(m_cur) && (y % TILE == 0));
        if (go) begin
          m_cur = m_pend;
          e.move = move_bits(m_pend);
          m_pend = 0;
          m_tmo = 0;
        end else begin
          m_tmo++;
          if (m_tmo == TMO) begin
            m_pend = 0;
            m_tmo = 0;
          end
        end
      end
    end
    e.cur = m_cur;
    e.pend = m_pend;
    return e;
  endfunction

  task automatic frame(input bit [3:0] keys, input int x, input int y);
    exp_t e;
    @(posedge clk); #1;
    {key_up, key_down, key_left, key_right} = keys;
    topLeftX = 11'(x);
    topLeftY = 11'(y);
    if (m_idle) begin
      e.chk = 1'b0; e.pend_s = 0; e.move = 0; e.cur = 0; e.pend = 0;
      m_idle = 1'b0;
    end else begin
      e = model_frame(keys, x, y);
    end
    sb.push_back(e);
    startOfFrame = 1'b1;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    repeat (FRAME - 2) @(posedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    resetN = 1'b0;
    #2;
    check("reset_move", int'({move_down, move_right, move_up, move_left}), 0);
    check("reset_cur", int'(cur_dir), 0);
    check("reset_pending", int'(pending_dir), 0);
    model_reset();
    @(posedge clk); #1;
    resetN = 1'b1;
  endtask

  // Monitor: each frame start pops one expectation and checks T+1, T+2 and T+3
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (startOfFrame && resetN) begin
        if (sb.size() == 0) begin
          check("frame_without_expectation", 1, 0);
        end else begin
          e = sb.pop_front();
          if (e.chk) begin
            @(negedge clk);
            check("hold_end", int'({move_down, move_right, move_up, move_left}), 0);
            @(negedge clk);
            check("pending_after_sample", int'(pending_dir), e.pend_s);
            @(negedge clk);
            check("move", int'({move_down, move_right, move_up, move_left}), e.move);
            check("cur_dir", int'(cur_dir), e.cur);
            check("pending_after_decide", int'(pending_dir), e.pend);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [3:0] keys;
    int x, y, wait_cnt;
    model_reset();
    repeat (3) @(posedge clk);
    apply_reset();
    frame(0, 0, 0);                       // leaves IDLE_ST
    // Immediate start: right held for frames 1-3
    repeat (3) frame(K_R, 0, 0);
    repeat (2) frame(0, 0, 0);
    // Perpendicular turn waits for X alignment
    repeat (2) frame(K_U, 100, 0);
    frame(0, 128, 0);
    repeat (2) frame(0, 128, 0);
    // Back to right (Y aligned), then reversal with X misaligned
    repeat (2) frame(K_R, 101, 0);
    repeat (2) frame(0, 101, 0);
    repeat (2) frame(K_L, 101, 0);
    repeat (2) frame(0, 101, 0);
    // Get moving down, then a left request that can never align and times out
    repeat (2) frame(K_D, 0, 5);
    repeat (2) frame(0, 0, 5);
    repeat (2) frame(K_L, 0, 37);
    repeat (16) frame(0, 0, 69);
    // Simultaneous up+left, then a one-frame glitch
    repeat (2) frame(K_U | K_L, 3, 3);
    repeat (2) frame(0, 3, 3);
    frame(K_R, 3, 3);
    repeat (3) frame(0, 3, 3);
    // Reset while move_down is held, then a fresh full debounce
    repeat (2) frame(K_D, 7, 7);
    apply_reset();
    frame(K_D, 7, 7);                     // leaves IDLE_ST
    repeat (3) frame(K_D, 7, 7);
    repeat (2) frame(0, 7, 7);
    // Randomized frames with sticky keys and mixed alignment, occasional reset
    keys = '0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 3) == 0) keys[i] = ~keys[i];
      if ($urandom_range(0, 1) == 1) x = int'($urandom_range(0, 63)) * TILE - 1024;
      else x = int'($urandom_range(0, 2047)) - 1024;
      if ($urandom_range(0, 1) == 1) y = int'($urandom_range(0, 63)) * TILE - 1024;
      else y = int'($urandom_range(0, 2047)) - 1024;
      if ($urandom_range(0, 99) == 0) apply_reset();
      frame(keys, x, y);
    end
    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 50) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
